// File: rtl/mips_pkg.sv
// Shared opcodes, FSM state encoding and control-field encodings for the
// multi-cycle MIPS control path.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_IEXEC, S_IWB, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_JAL, S_TRAP
    } state_e;

    typedef enum logic [1:0] {REG_DST_RT = 2'b00, REG_DST_RD = 2'b01, REG_DST_RA = 2'b10} reg_dst_e;
    typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MDR = 2'b01, WB_PC = 2'b10} wb_sel_e;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;
    typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_BRANCH, PC_JUMP} pc_sel_e;

    typedef struct packed {
        logic     mem_req;
        logic     mem_we;
        logic     addr_alu;   // 1: data access at alu_result, 0: fetch at pc
        logic     reg_write;
        reg_dst_e reg_dst;
        wb_sel_e  wb_sel;
        logic     alu_src;
        alu_op_e  alu_op;
        logic     ir_load;
        logic     mdr_load;
        pc_sel_e  pc_sel;
        logic     retire;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_fsm.sv
// Combinational next-state and control decode for the multi-cycle FSM.
// MIPS_ILLEGAL_TRAP_EN sends unknown opcodes to a terminal TRAP state.
module mips_mc_fsm
    import mips_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       alu_zero_i,
    output state_e     next_o,
    output ctrl_t      ctrl_o
);

`ifdef MIPS_ILLEGAL_TRAP_EN
    localparam state_e UNKNOWN_NEXT = S_TRAP;
`else
    localparam state_e UNKNOWN_NEXT = S_FETCH;
`endif

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        next_o = state_i;
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req = 1'b1;
                if (mem_ready_i) begin
                    ctrl_o.ir_load = 1'b1;
                    ctrl_o.pc_sel  = PC_INC;
                    next_o         = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (opcode_i)
                    OP_RTYPE:      next_o = S_EXEC;
                    OP_ADDI:       next_o = S_IEXEC;
                    OP_LW, OP_SW:  next_o = S_MEMADR;
                    OP_BEQ:        next_o = S_BRANCH;
                    OP_J:          next_o = S_JUMP;
                    OP_JAL:        next_o = S_JAL;
                    default:       next_o = UNKNOWN_NEXT;
                endcase
            end
            S_EXEC: begin
                ctrl_o.alu_op = ALU_FUNCT;
                next_o        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = REG_DST_RD;
                next_o           = S_FETCH;
            end
            S_IEXEC: begin
                ctrl_o.alu_src = 1'b1;
                next_o         = S_IWB;
            end
            S_IWB: begin
                ctrl_o.reg_write = 1'b1;
                next_o           = S_FETCH;
            end
            S_MEMADR: begin
                ctrl_o.alu_src = 1'b1;
                next_o         = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.addr_alu = 1'b1;
                if (mem_ready_i) begin
                    ctrl_o.mdr_load = 1'b1;
                    next_o          = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.wb_sel    = WB_MDR;
                next_o           = S_FETCH;
            end
            S_MEMWR: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.mem_we   = 1'b1;
                ctrl_o.addr_alu = 1'b1;
                if (mem_ready_i) next_o = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_o.alu_op = ALU_SUB;
                ctrl_o.pc_sel = alu_zero_i ? PC_BRANCH : PC_HOLD;
                next_o        = S_FETCH;
            end
            S_JUMP: begin
                ctrl_o.pc_sel = PC_JUMP;
                next_o        = S_FETCH;
            end
            S_JAL: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = REG_DST_RA;
                ctrl_o.wb_sel    = WB_PC;
                ctrl_o.pc_sel    = PC_JUMP;
                next_o           = S_FETCH;
            end
            S_TRAP:  next_o = S_TRAP;
            default: next_o = S_FETCH;
        endcase
        ctrl_o.retire = (state_i != S_FETCH) && (next_o == S_FETCH);
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control path: PC/IR/MDR, retired counter and FSM state.
// MIPS_ILLEGAL_TRAP_EN enables the sticky illegal-opcode trap.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_ready,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    input  logic [XLEN-1:0]  branch_target,
    input  logic [XLEN-1:0]  jump_target,
    output logic [XLEN-1:0]  pc,
    output logic [31:0]      ir,
    output logic [XLEN-1:0]  mdr,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    state_e           state_q, state_d;
    ctrl_t            ctrl;
    logic [XLEN-1:0]  pc_q, pc_d, mdr_q, mdr_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    mips_mc_fsm u_fsm (
        .state_i     (state_q),
        .opcode_i    (ir_q[31:26]),
        .mem_ready_i (mem_ready),
        .alu_zero_i  (alu_zero),
        .next_o      (state_d),
        .ctrl_o      (ctrl)
    );

    always_comb begin
        unique case (ctrl.pc_sel)
            PC_INC:    pc_d = pc_q + XLEN'(4);
            PC_BRANCH: pc_d = branch_target;
            PC_JUMP:   pc_d = jump_target;
            default:   pc_d = pc_q;
        endcase
        ir_d      = ctrl.ir_load  ? 32'(mem_rdata) : ir_q;
        mdr_d     = ctrl.mdr_load ? mem_rdata      : mdr_q;
        retired_d = retired_q + CNT_W'(ctrl.retire);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            retired_q <= retired_d;
        end
    end

`ifdef MIPS_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                illegal_q <= 1'b0;
        else if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Gating with reset drops an in-flight request the moment reset asserts.
    assign mem_req   = ctrl.mem_req & reset;
    assign mem_we    = ctrl.mem_we & reset;
    assign mem_addr  = ctrl.addr_alu ? alu_result : pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign reg_write = ctrl.reg_write;
    assign reg_dst   = ctrl.reg_dst;
    assign wb_sel    = ctrl.wb_sel;
    assign alu_src   = ctrl.alu_src;
    assign alu_op    = ctrl.alu_op;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed self-checking bench for mips_mc_ctrl with RESET_PC = 0x100.
// Honours MIPS_ILLEGAL_TRAP_EN for the unknown-opcode scenario.
module tb_mips_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, alu_zero;
    logic [31:0] mem_addr, mem_rdata, alu_result, branch_target, jump_target;
    logic [31:0] pc, ir, mdr, retired;
    logic        reg_write, alu_src, illegal;
    logic [1:0]  reg_dst, wb_sel, alu_op;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] lw_pc;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.XLEN(32), .RESET_PC(32'h100), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .pc            (pc),
        .ir            (ir),
        .mdr           (mdr),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .wb_sel        (wb_sel),
        .alu_src       (alu_src),
        .alu_op        (alu_op),
        .retired       (retired),
        .illegal       (illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b1; mem_rdata = '0; alu_result = '0;
        alu_zero = 1'b0; branch_target = '0; jump_target = '0;
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_pc", pc, 32'h100);
        check("rst_ir", ir, 0);
        check("rst_retired", retired, 0);
        check("rst_reg_write", reg_write, 0);
        check("rst_illegal", illegal, 0);

        // R-type add, zero wait
        reset = 1'b1; mem_rdata = 32'h012A4020; #1;
        check("r_fetch_req", mem_req, 1);
        check("r_fetch_addr", mem_addr, 32'h100);
        check("r_fetch_we", mem_we, 0);
        tick();
        check("r_dec_pc", pc, 32'h104);
        check("r_dec_ir", ir, 32'h012A4020);
        check("r_dec_retired", retired, 0);
        check("r_dec_req", mem_req, 0);
        check("r_dec_rw", reg_write, 0);
        tick();
        check("r_exec_aluop", alu_op, 2'b10);
        check("r_exec_alusrc", alu_src, 0);
        check("r_exec_rw", reg_write, 0);
        tick();
        check("r_wb_rw", reg_write, 1);
        check("r_wb_dst", reg_dst, 2'b01);
        check("r_wb_sel", wb_sel, 2'b00);
        tick();
        check("r_done_rw", reg_write, 0);
        check("r_done_retired", retired, 1);
        check("r_done_addr", mem_addr, 32'h104);

        // lw with two data wait states
        mem_rdata = 32'h8D090008;
        tick();
        check("lw_dec_pc", pc, 32'h108);
        tick();
        check("lw_adr_alusrc", alu_src, 1);
        check("lw_adr_aluop", alu_op, 2'b00);
        alu_result = 32'h40; mem_ready = 1'b0;
        tick();
        check("lw_rd1_req", mem_req, 1);
        check("lw_rd1_addr", mem_addr, 32'h40);
        check("lw_rd1_we", mem_we, 0);
        tick();
        check("lw_rd2_addr", mem_addr, 32'h40);
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
        check("lw_rd3_addr", mem_addr, 32'h40);
        check("lw_rd3_req", mem_req, 1);
        tick();
        check("lw_wb_mdr", mdr, 32'hDEADBEEF);
        check("lw_wb_rw", reg_write, 1);
        check("lw_wb_sel", wb_sel, 2'b01);
        check("lw_wb_dst", reg_dst, 2'b00);
        check("lw_wb_retired", retired, 1);
        tick();
        check("lw_done_retired", retired, 2);
        check("lw_done_addr", mem_addr, 32'h108);

        // beq taken
        mem_rdata = 32'h11090004;
        tick(); tick();
        check("beq_t_aluop", alu_op, 2'b01);
        check("beq_t_alusrc", alu_src, 0);
        alu_zero = 1'b1; branch_target = 32'h200;
        tick();
        check("beq_t_addr", mem_addr, 32'h200);
        check("beq_t_retired", retired, 3);

        // beq not taken
        tick(); tick();
        alu_zero = 1'b0; branch_target = 32'h300;
        tick();
        check("beq_nt_addr", mem_addr, 32'h204);
        check("beq_nt_retired", retired, 4);

        // j to 0x100
        mem_rdata = 32'h08000040;
        tick(); tick();
        jump_target = 32'h100;
        tick();
        check("j_addr", mem_addr, 32'h100);
        check("j_retired", retired, 5);

        // jal at 0x100
        mem_rdata = 32'h0C000100;
        tick(); tick();
        jump_target = 32'h400; #1;
        check("jal_rw", reg_write, 1);
        check("jal_dst", reg_dst, 2'b10);
        check("jal_sel", wb_sel, 2'b10);
        check("jal_pc", pc, 32'h104);
        tick();
        check("jal_addr", mem_addr, 32'h400);
        check("jal_retired", retired, 6);

        // addi
        mem_rdata = 32'h21090005;
        tick(); tick();
        check("addi_alusrc", alu_src, 1);
        check("addi_aluop", alu_op, 2'b00);
        check("addi_exec_rw", reg_write, 0);
        tick();
        check("addi_wb_rw", reg_write, 1);
        check("addi_wb_dst", reg_dst, 2'b00);
        tick();
        check("addi_retired", retired, 7);
        check("addi_addr", mem_addr, 32'h404);

        // sw, zero wait
        mem_rdata = 32'hAD090004;
        tick(); tick();
        alu_result = 32'h80;
        tick();
        check("sw_req", mem_req, 1);
        check("sw_we", mem_we, 1);
        check("sw_addr", mem_addr, 32'h80);
        check("sw_rw", reg_write, 0);
        tick();
        check("sw_retired", retired, 8);
        check("sw_addr_next", mem_addr, 32'h408);

        // unknown opcode 0x3F
        mem_rdata = 32'hFC000000;
        tick(); tick();
`ifdef MIPS_ILLEGAL_TRAP_EN
        check("trap_illegal", illegal, 1);
        for (int i = 0; i < 20; i++) begin
            check("trap_req", mem_req, 0);
            tick();
        end
        check("trap_retired", retired, 8);
        reset = 1'b0; #1;
        check("trap_rst_illegal", illegal, 0);
        check("trap_rst_pc", pc, 32'h100);
        tick();
        reset = 1'b1; #1;
        lw_pc = 32'h100;
`else
        check("nop_addr", mem_addr, 32'h40C);
        check("nop_retired", retired, 9);
        check("nop_illegal", illegal, 0);
        lw_pc = 32'h40C;
`endif

        // reset during a MEMRD wait
        check("lw2_fetch_addr", mem_addr, lw_pc);
        mem_rdata = 32'h8D090008;
        tick(); tick();
        alu_result = 32'h44; mem_ready = 1'b0;
        tick();
        check("lw2_rd_req", mem_req, 1);
        #2 reset = 1'b0; #1;
        check("midrst_req", mem_req, 0);
        check("midrst_pc", pc, 32'h100);
        check("midrst_retired", retired, 0);
        tick();
        reset = 1'b1; mem_ready = 1'b1; #1;
        check("post_rst_req", mem_req, 1);
        check("post_rst_addr", mem_addr, 32'h100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle successor to the single-cycle CPU's control path. It owns PC, instruction register (IR), memory data register (MDR), a retired-instruction counter and the multi-cycle control FSM. It drives a single shared instruction/data memory through a req/ready handshake, so memory may insert wait states. The existing datapath (register file, ALU, sign-extend, target adders) consumes its control outputs.

Parameters:
- XLEN, 32: PC/address/data width (>=16).
- RESET_PC, 0: PC value after reset.
- CNT_W, 32: retired-instruction counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable, valid with mem_req.
- mem_addr  out  XLEN  request address.
- mem_ready  in  1  transaction completes on the cycle where mem_req&&mem_ready.
- mem_rdata  in  XLEN  read data, valid when mem_ready.
- alu_result  in  XLEN  datapath ALU output.
- alu_zero  in  1  ALU zero flag.
- branch_target  in  XLEN  PC+4+(simm<<2), computed by datapath.
- jump_target  in  XLEN  {pc[XLEN-1:28], ir[25:0], 2'b00}.
- pc  out  XLEN  current PC (already +4 after FETCH).
- ir  out  32  instruction register.
- mdr  out  XLEN  memory data register.
- reg_write  out  1  regfile write strobe, one cycle.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- wb_sel  out  2  00 alu_result, 01 mdr, 10 pc (link).
- alu_src  out  1  0 reg rt, 1 sign-extended imm.
- alu_op  out  2  00 add, 01 sub, 10 decode funct.
- retired  out  CNT_W  instructions completed.
- illegal  out  1  sticky illegal-opcode flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert by the system) sets:
  - state=FETCH; pc=RESET_PC; ir=0; mdr=0; retired=0; illegal=0.
  - All strobes 0.
  - mem_req rises in the first cycle after release.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc; hold stable until ready.
  - On ready: ir<=mem_rdata[31:0]; pc<=pc+4 (wraps mod 2^XLEN); go to DECODE.
- DECODE: one cycle, no strobes. Next state by ir[31:26]:
  - 0x00 -> EXEC
  - 0x08 (addi) -> IEXEC
  - 0x23 (lw) or 0x2B (sw) -> MEMADR
  - 0x04 (beq) -> BRANCH
  - 0x02 (j) -> JUMP
  - 0x03 (jal) -> JAL
  - anything else -> FETCH (treated as NOP; retired still increments).
- EXEC: alu_src=0, alu_op=10 -> ALUWB.
- ALUWB: reg_write=1, reg_dst=01, wb_sel=00 -> FETCH.
- IEXEC: alu_src=1, alu_op=00 -> IWB.
- IWB: reg_write=1, reg_dst=00, wb_sel=00 -> FETCH.
- MEMADR: alu_src=1, alu_op=00; next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, mem_addr=alu_result. On ready: mdr<=mem_rdata, then MEMWB.
- MEMWB: reg_write=1, reg_dst=00, wb_sel=01 -> FETCH.
- MEMWR: mem_req=1, mem_we=1, mem_addr=alu_result. On ready -> FETCH.
- BRANCH: alu_src=0, alu_op=01. If alu_zero, pc<=branch_target. -> FETCH.
- JUMP: pc<=jump_target -> FETCH.
- JAL: reg_write=1, reg_dst=10, wb_sel=10 (pc is already +4), pc<=jump_target in the same edge -> FETCH.
- retired increments by 1 on every transition into FETCH from a non-FETCH state. It wraps at 2^CNT_W.
- Zero-wait latencies (cycles, FETCH inclusive): R/addi 4, lw 5, sw 4, beq/j/jal 3. Each memory wait cycle adds 1.
- All control outputs are Moore (decoded from state/ir). mem_ready is sampled only in FETCH/MEMRD/MEMWR and ignored elsewhere.
- Reset mid-transaction drops mem_req immediately (asynchronous). Memory must tolerate an abandoned request.

Optional Feature:
- Macro MIPS_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> TRAP state: illegal<=1, no further mem_req, retired frozen.
  - Leave TRAP only by reset.
- Undefined: unknown opcode is a NOP as above; illegal is tied to 0.

Decomposition:
- Package mips_pkg holds:
  - opcode constants;
  - state enum;
  - reg_dst/wb_sel/alu_op encodings.
- Sub-module mips_mc_fsm: combinational next-state and output decode from (state, opcode, mem_ready, alu_zero). mips_mc_ctrl keeps the registers.

Test Plan:
- Reset with RESET_PC=0x100, mem_ready=1 -> first request has mem_addr=0x100, mem_we=0; after FETCH, pc=0x104, retired=0.
- R-type add (0x012A4020), zero wait -> reg_write high only in cycle 4 with reg_dst=01, wb_sel=00; retired=1 after cycle 4.
- lw (0x8D090008) with alu_result=0x40 and 2 wait states on the data access -> mem_addr=0x40 held 3 cycles; mdr=mem_rdata; MEMWB has wb_sel=01; 7 cycles total.
- beq with alu_zero=1 and branch_target=0x200 -> next fetch address 0x200. Repeat with alu_zero=0 -> next fetch at pc+4.
- jal at pc=0x100 with jump_target=0x400 -> reg_write with reg_dst=10, wb_sel=10 and pc output 0x104 during JAL; next fetch at 0x400.
- Opcode 0x3F:
  - With MIPS_ILLEGAL_TRAP_EN: illegal=1, mem_req stays 0 for 20 cycles; reset clears illegal.
  - Without the macro: next fetch at pc+4, retired increments.
  - Also assert reset during a MEMRD wait: mem_req=0 immediately, pc=RESET_PC.
